ram_march_tester: RTL and testbench
===================================

Name: ram_march_tester

Overview:
- Initiator/master for the codebase's dual-port synchronous RAM. It drives the RAM's write and read ports and checks the returned data_out.
- Runs a 4-element March C- style test over every address, then reports pass/fail with the first-failure details.
- Sits beside the RAM as a built-in self-test engine. Software or a top-level FSM pulses start and reads the result.

Parameters:
- RAM_width, 8, data word width in bits
- RAM_depth, 256, number of words tested (addresses 0..RAM_depth-1)
- address_size, 8, address width; RAM_depth <= 2**address_size

Ports:
- clk  input  1  single system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a test; ignored while busy
- pattern  input  RAM_width  background pattern P, sampled on the accepted start cycle
- write_enable  output  1  to RAM write port
- write_address  output  address_size  to RAM write port
- data_in  output  RAM_width  write data to RAM
- read_enable  output  1  to RAM read port
- read_address  output  address_size  to RAM read port
- data_out  input  RAM_width  RAM read data, valid the cycle after read_enable is sampled high
- busy  output  1  high from the cycle after start is accepted until completion
- done  output  1  one-cycle pulse at completion (pass or fail)
- pass  output  1  result of the last completed test; held until the next accepted start
- fail_address  output  address_size  address of the first miscompare
- fail_expected  output  RAM_width  expected word at the first miscompare
- fail_actual  output  RAM_width  data_out captured at the first miscompare

Behaviour:
- Reset: state IDLE. All outputs 0, including enables, addresses, data_in, busy, done, pass and fail_*. Reset asserted mid-test aborts the test immediately, with no further RAM writes.
- Registered outputs: every output is a register.
- IDLE: when start=1, latch P=pattern, addr=0, clear pass/fail_*, go to M0. busy=1 from the next cycle.
- M0 (ascending, write P): one cycle per address, write_enable=1, write_address=addr, data_in=P. After addr=RAM_depth-1, go to M1 with addr=0.
- M1 (ascending, r(P) w(~P)): two cycles per address.
  - RD sub-cycle: read_enable=1, read_address=addr.
  - CHK sub-cycle: compare data_out to P. If equal, write ~P to addr and advance addr. After the last address, go to M2 with addr=RAM_depth-1.
- M2 (descending, r(~P) w(P)): same two-cycle scheme, expected ~P, writes P, addr decrements. After addr=0, go to M3 with addr=RAM_depth-1.
- M3 (descending, r(P)): RD/CHK pair per address, no write. After addr=0, go to FINISH.
- FINISH: for one cycle busy=0, done=1, pass=1. Then IDLE.
- Miscompare in any CHK cycle:
  - Suppress that cycle's write.
  - Capture fail_address=addr, fail_expected, fail_actual=data_out.
  - Go to FAILED. FAILED: for one cycle busy=0, done=1, pass=0. Then IDLE.
- Timing: pass-run length is exactly 7*RAM_depth cycles from the first M0 write to the last CHK, then done pulses on the following cycle.
- Enable hygiene: write_enable and read_enable are each high only in the cycles stated above, never both high for the same address in the same cycle. Addresses and data hold their last values when enables are low.
- No wrap: the address counter never wraps past 0 or RAM_depth-1. Element transitions reload addr explicitly.
- start during busy, FINISH or FAILED is ignored. start in the same cycle as reset is ignored.

Test Plan:
- Reset, start with pattern=8'hAA, healthy RAM: done pulses exactly 1793 cycles after the start cycle, with pass=1, fail_*=0 and busy=0.
- Verify the RAM image after the pass run: all 256 locations hold 8'hAA. A scoreboard also confirms write order: 0..255 writes AA, then 0..255 writes 55, then 255..0 writes AA.
- Force a bench-model stuck-at-0 on bit 1 at address 8'h23, with pattern=8'hAA: fail in M1 with fail_address=8'h23, fail_expected=8'hAA, fail_actual=8'hA8, pass=0. Write to 0x23 is suppressed.
- Force a stuck-at-1 on bit 0 at address 8'h00, with pattern=8'h00: fail in M1 at 0x00 with expected 8'h00, actual 8'h01. done pulses 258 cycles after start.
- Pulse start again at cycle 100 of a run: ignored, with no restart, no extra done, and total length unchanged.
- Assert reset for one cycle mid-M2: on the next cycle all outputs are 0, with no further write_enable. A following start runs a full test to pass=1.

Source files
------------

// File: rtl/ram_march_tester_if.sv
// RAM access bus between the march tester and a dual-port synchronous RAM.
//   master: drives the write port (write_enable, write_address, data_in) and
//           the read port (read_enable, read_address); receives data_out.
//   slave : the RAM side of the same signals.
// data_out is expected one cycle after read_enable is sampled high.
interface ram_march_tester_if #(
  parameter int RAM_width    = 8,
  parameter int address_size = 8
);
  logic                    write_enable;
  logic [address_size-1:0] write_address;
  logic [RAM_width-1:0]    data_in;
  logic                    read_enable;
  logic [address_size-1:0] read_address;
  logic [RAM_width-1:0]    data_out;

  modport master (
    output write_enable, write_address, data_in, read_enable, read_address,
    input  data_out
  );

  modport slave (
    input  write_enable, write_address, data_in, read_enable, read_address,
    output data_out
  );
endinterface

// File: rtl/ram_march_tester.sv
// March C- style built-in self-test engine for a dual-port synchronous RAM.
// Elements: M0 up w(P); M1 up r(P) w(~P); M2 down r(~P) w(P); M3 down r(P).
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   start, pattern  - one-cycle test request and background pattern P
//   ram (master)    - RAM write/read ports and returned data_out
//   busy, done      - test in progress / one-cycle completion pulse
//   pass, fail_*    - result of the last test and first-miscompare details
// Every output is a register. Requires RAM_depth >= 2.
module ram_march_tester #(
  parameter int RAM_width    = 8,
  parameter int RAM_depth    = 256,
  parameter int address_size = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [RAM_width-1:0]    pattern,
  ram_march_tester_if.master      ram,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [address_size-1:0] fail_address,
  output logic [RAM_width-1:0]    fail_expected,
  output logic [RAM_width-1:0]    fail_actual
);

  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_FINISH, S_FAILED
  } state_t;

  // Sub-cycle inside a read element: RD issues the read, CHK sees data_out,
  // WR is a lone write slot used only at the M1->M2 boundary.
  typedef enum logic [1:0] {SUB_RD, SUB_CHK, SUB_WR} sub_t;

  localparam logic [address_size-1:0] LAST = address_size'(RAM_depth - 1);
  localparam logic [address_size-1:0] ONE  = address_size'(1);

  state_t                  state;
  sub_t                    sub;
  logic [address_size-1:0] addr;
  logic [RAM_width-1:0]    p;
  logic [RAM_width-1:0]    expected;
  logic                    match;

  always_comb begin
    expected = (state == S_M2) ? ~p : p;
    match    = (ram.data_out == expected);
  end

  // Write-backs are issued in the cycle after CHK and overlap the next read
  // of a different address, which keeps two cycles per address. The first
  // M1 read overlaps the last M0 write, and the extra WR slot at M1->M2
  // avoids reading address LAST while it is being written; the two cancel
  // so a passing run is 7*RAM_depth cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      sub               <= SUB_RD;
      addr              <= '0;
      p                 <= '0;
      ram.write_enable  <= 1'b0;
      ram.write_address <= '0;
      ram.data_in       <= '0;
      ram.read_enable   <= 1'b0;
      ram.read_address  <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
      fail_address      <= '0;
      fail_expected     <= '0;
      fail_actual       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state             <= S_M0;
            p                 <= pattern;
            addr              <= '0;
            busy              <= 1'b1;
            pass              <= 1'b0;
            fail_address      <= '0;
            fail_expected     <= '0;
            fail_actual       <= '0;
            ram.write_enable  <= 1'b1;
            ram.write_address <= '0;
            ram.data_in       <= pattern;
          end
        end

        S_M0: begin
          if (addr == LAST) begin
            state            <= S_M1;
            sub              <= SUB_CHK;
            addr             <= '0;
            ram.write_enable <= 1'b0;
            ram.read_enable  <= 1'b0;
          end else begin
            addr              <= addr + ONE;
            ram.write_enable  <= 1'b1;
            ram.write_address <= addr + ONE;
            ram.data_in       <= p;
            if (addr + ONE == LAST) begin
              ram.read_enable  <= 1'b1;
              ram.read_address <= '0;
            end
          end
        end

        S_M1, S_M2, S_M3: begin
          case (sub)
            SUB_RD: begin
              ram.write_enable <= 1'b0;
              ram.read_enable  <= 1'b0;
              sub              <= SUB_CHK;
            end
            SUB_WR: begin
              ram.write_enable <= 1'b0;
              ram.read_enable  <= 1'b1;
              ram.read_address <= addr;
              sub              <= SUB_RD;
            end
            default: begin
              if (!match) begin
                state            <= S_FAILED;
                ram.write_enable <= 1'b0;
                ram.read_enable  <= 1'b0;
                busy             <= 1'b0;
                done             <= 1'b1;
                pass             <= 1'b0;
                fail_address     <= addr;
                fail_expected    <= expected;
                fail_actual      <= ram.data_out;
              end else begin
                ram.write_enable <= 1'b0;
                ram.read_enable  <= 1'b0;
                sub              <= SUB_RD;
                case (state)
                  S_M1: begin
                    ram.write_enable  <= 1'b1;
                    ram.write_address <= addr;
                    ram.data_in       <= ~p;
                    if (addr == LAST) begin
                      state <= S_M2;
                      sub   <= SUB_WR;
                      addr  <= LAST;
                    end else begin
                      addr             <= addr + ONE;
                      ram.read_enable  <= 1'b1;
                      ram.read_address <= addr + ONE;
                    end
                  end
                  S_M2: begin
                    ram.write_enable  <= 1'b1;
                    ram.write_address <= addr;
                    ram.data_in       <= p;
                    ram.read_enable   <= 1'b1;
                    if (addr == '0) begin
                      state            <= S_M3;
                      addr             <= LAST;
                      ram.read_address <= LAST;
                    end else begin
                      addr             <= addr - ONE;
                      ram.read_address <= addr - ONE;
                    end
                  end
                  default: begin
                    if (addr == '0) begin
                      state <= S_FINISH;
                      busy  <= 1'b0;
                      done  <= 1'b1;
                      pass  <= 1'b1;
                    end else begin
                      addr             <= addr - ONE;
                      ram.read_enable  <= 1'b1;
                      ram.read_address <= addr - ONE;
                    end
                  end
                endcase
              end
            end
          endcase
        end

        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_tester.sv
module tb_ram_march_tester;
  localparam int W = 8;
  localparam int D = 256;
  localparam int A = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] pattern;
  logic         busy, done, pass;
  logic [A-1:0] fail_address;
  logic [W-1:0] fail_expected, fail_actual;

  int checks = 0;
  int errors = 0;

  ram_march_tester_if #(.RAM_width(W), .address_size(A)) bus ();

  ram_march_tester #(.RAM_width(W), .RAM_depth(D), .address_size(A)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pattern       (pattern),
    .ram           (bus),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_address  (fail_address),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual)
  );

  always #5 clk = ~clk;

  // Bench RAM with optional stuck-at faults applied on read.
  logic [W-1:0]   mem [D];
  logic [A-1:0]   sa0_addr, sa1_addr;
  logic [W-1:0]   sa0_mask, sa1_mask;
  logic [A+W-1:0] wlog [$];
  int             conflicts = 0;

  function automatic logic [W-1:0] faulty(input logic [A-1:0] a, input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
    if (a == sa0_addr) r = r & ~sa0_mask;
    if (a == sa1_addr) r = r | sa1_mask;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.write_enable) begin
      mem[bus.write_address] <= bus.data_in;
      wlog.push_back({bus.write_address, bus.data_in});
    end
    if (bus.read_enable) bus.data_out <= faulty(bus.read_address, mem[bus.read_address]);
    if (bus.write_enable && bus.read_enable && bus.write_address == bus.read_address)
      conflicts <= conflicts + 1;
  end

  function automatic logic [52:0] all_outs();
    return {bus.write_enable, bus.write_address, bus.data_in, bus.read_enable,
            bus.read_address, busy, done, pass, fail_address, fail_expected, fail_actual};
  endfunction

  // Starts a test and counts edges from the start edge until done is seen.
  task automatic run_test(input logic [W-1:0] pat, input int repulse,
                          output int lat, output int ndone, output logic busy1);
    lat   = -1;
    ndone = 0;
    busy1 = 1'b0;
    wlog.delete();
    pattern = pat;
    start   = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        start = 1'b0;
        busy1 = busy;
      end
      if (repulse != 0 && i == repulse - 1) begin
        start   = 1'b1;
        pattern = 8'h00;
      end
      if (repulse != 0 && i == repulse) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (lat >= 0 && i >= lat + 6) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    pattern = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bus.write_enable !== 1'b0) begin
      errors++;
      $display("FAIL start_with_reset busy=%b we=%b want 0 0", busy, bus.write_enable);
    end
  endtask

  task automatic test_pass_run();
    int lat, nd, bad_mem, bad_ord;
    logic b1;
    logic [A+W-1:0] e;
    sa0_mask = '0; sa1_mask = '0;
    conflicts = 0;
    run_test(8'hAA, 0, lat, nd, b1);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL pass_busy_early got %b want 1", b1); end
    checks++; if (lat != 1793) begin errors++; $display("FAIL pass_latency got %0d want 1793", lat); end
    checks++; if (nd != 1) begin errors++; $display("FAIL pass_done_count got %0d want 1", nd); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_flag got %b want 1", pass); end
    checks++;
    if ({fail_address, fail_expected, fail_actual} !== 24'h0) begin
      errors++;
      $display("FAIL pass_fail_fields got %h want 0", {fail_address, fail_expected, fail_actual});
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy_end got %b want 0", busy); end
    bad_mem = 0;
    for (int a = 0; a < D; a++) if (mem[a] !== 8'hAA) bad_mem++;
    checks++; if (bad_mem != 0) begin errors++; $display("FAIL pass_ram_image bad=%0d want 0", bad_mem); end
    checks++;
    if (wlog.size() != 768) begin errors++; $display("FAIL pass_write_count got %0d want 768", wlog.size()); end
    bad_ord = 0;
    for (int i = 0; i < wlog.size() && i < 768; i++) begin
      if (i < 256)      e = {A'(i), 8'hAA};
      else if (i < 512) e = {A'(i - 256), 8'h55};
      else              e = {A'(767 - i), 8'hAA};
      if (wlog[i] !== e) bad_ord++;
    end
    checks++; if (bad_ord != 0) begin errors++; $display("FAIL pass_write_order bad=%0d want 0", bad_ord); end
    checks++; if (conflicts != 0) begin errors++; $display("FAIL pass_same_addr_rw got %0d want 0", conflicts); end
  endtask

  task automatic test_stuck0();
    int lat, nd, n23;
    logic b1;
    sa0_addr = 8'h23; sa0_mask = 8'h02; sa1_mask = '0;
    run_test(8'hAA, 0, lat, nd, b1);
    // M1 CHK of address k is cycle 257+2k; done follows one cycle later.
    checks++; if (lat != 257 + 2 * 35 + 1) begin errors++; $display("FAIL sa0_latency got %0d want 328", lat); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL sa0_pass got %b want 0", pass); end
    checks++; if (fail_address !== 8'h23) begin errors++; $display("FAIL sa0_addr got %h want 23", fail_address); end
    checks++; if (fail_expected !== 8'hAA) begin errors++; $display("FAIL sa0_expected got %h want aa", fail_expected); end
    checks++; if (fail_actual !== 8'hA8) begin errors++; $display("FAIL sa0_actual got %h want a8", fail_actual); end
    n23 = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i][A+W-1:W] == 8'h23) n23++;
    checks++; if (n23 != 1) begin errors++; $display("FAIL sa0_write_suppressed writes_to_23=%0d want 1", n23); end
    checks++; if (wlog.size() != 291) begin errors++; $display("FAIL sa0_write_count got %0d want 291", wlog.size()); end
    checks++; if (nd != 1) begin errors++; $display("FAIL sa0_done_count got %0d want 1", nd); end
    sa0_mask = '0;
  endtask

  task automatic test_stuck1();
    int lat, nd;
    logic b1;
    sa1_addr = 8'h00; sa1_mask = 8'h01;
    run_test(8'h00, 0, lat, nd, b1);
    checks++; if (lat != 258) begin errors++; $display("FAIL sa1_latency got %0d want 258", lat); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL sa1_pass got %b want 0", pass); end
    checks++;
    if ({fail_address, fail_expected, fail_actual} !== {8'h00, 8'h00, 8'h01}) begin
      errors++;
      $display("FAIL sa1_fields got %h want 000001", {fail_address, fail_expected, fail_actual});
    end
    checks++; if (wlog.size() != 256) begin errors++; $display("FAIL sa1_write_count got %0d want 256", wlog.size()); end
    sa1_mask = '0;
  endtask

  task automatic test_start_while_busy();
    int lat, nd, bad_mem;
    logic b1;
    run_test(8'hAA, 100, lat, nd, b1);
    checks++; if (lat != 1793) begin errors++; $display("FAIL rebusy_latency got %0d want 1793", lat); end
    checks++; if (nd != 1) begin errors++; $display("FAIL rebusy_done_count got %0d want 1", nd); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rebusy_pass got %b want 1", pass); end
    bad_mem = 0;
    for (int a = 0; a < D; a++) if (mem[a] !== 8'hAA) bad_mem++;
    checks++; if (bad_mem != 0) begin errors++; $display("FAIL rebusy_ram_image bad=%0d want 0", bad_mem); end
  endtask

  task automatic test_reset_abort();
    int lat, nd;
    logic b1;
    pattern = 8'hAA;
    start   = 1'b1;
    for (int i = 1; i < 1000; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL abort_outputs got %h want 0", all_outs()); end
    wlog.delete();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL abort_no_writes got %0d want 0", wlog.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    run_test(8'hAA, 0, lat, nd, b1);
    checks++; if (lat != 1793) begin errors++; $display("FAIL abort_rerun_latency got %0d want 1793", lat); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL abort_rerun_pass got %b want 1", pass); end
  endtask

  initial begin
    sa0_addr = '0; sa1_addr = '0; sa0_mask = '0; sa1_mask = '0;
    test_reset();
    test_pass_run();
    test_stuck0();
    test_stuck1();
    test_start_while_busy();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
